// File: rtl/fma_issue_ctrl_if.sv
// fma_issue_ctrl_if: handshake, pipeline and CSR signals of the FMA issue controller
// Ports are named from the controller's side: i_* are driven by the environment
// (master) and o_* are driven by the controller (slave).
//   req0/req1 : valid/ready/rm/tag from the two requesters
//   issue     : valid/src/rm to pipeline stage 0, pipe_en advances all stages
//   pipe flags: rounder flags and infinite-operand indication of the last stage
//   resp      : valid/ready/src/tag/illegal/fflags of the result
//   csr       : frm and fflags write ports and their current values
interface fma_issue_ctrl_if #(parameter int PARM_RM = 3, parameter int PARM_TAG = 4);
   logic                i_req0_valid, o_req0_ready;
   logic [PARM_RM-1:0]  i_req0_rm;
   logic [PARM_TAG-1:0] i_req0_tag;
   logic                i_req1_valid, o_req1_ready;
   logic [PARM_RM-1:0]  i_req1_rm;
   logic [PARM_TAG-1:0] i_req1_tag;
   logic                o_issue_valid, o_issue_src, o_pipe_en;
   logic [PARM_RM-1:0]  o_issue_rm;
   logic                i_pipe_invalid, i_pipe_overflow, i_pipe_underflow, i_pipe_inexact, i_pipe_inf_in;
   logic                o_resp_valid, i_resp_ready, o_resp_src, o_resp_illegal;
   logic [PARM_TAG-1:0] o_resp_tag;
   logic [4:0]          o_resp_fflags;
   logic                i_csr_frm_we, i_csr_fflags_we;
   logic [2:0]          i_csr_frm, o_frm;
   logic [4:0]          i_csr_fflags, o_fflags;
   modport master (
      output i_req0_valid, i_req0_rm, i_req0_tag, i_req1_valid, i_req1_rm, i_req1_tag,
      output i_pipe_invalid, i_pipe_overflow, i_pipe_underflow, i_pipe_inexact, i_pipe_inf_in,
      output i_resp_ready, i_csr_frm_we, i_csr_frm, i_csr_fflags_we, i_csr_fflags,
      input  o_req0_ready, o_req1_ready, o_issue_valid, o_issue_src, o_issue_rm, o_pipe_en,
      input  o_resp_valid, o_resp_src, o_resp_tag, o_resp_illegal, o_resp_fflags, o_frm, o_fflags
   );
   modport slave (
      input  i_req0_valid, i_req0_rm, i_req0_tag, i_req1_valid, i_req1_rm, i_req1_tag,
      input  i_pipe_invalid, i_pipe_overflow, i_pipe_underflow, i_pipe_inexact, i_pipe_inf_in,
      input  i_resp_ready, i_csr_frm_we, i_csr_frm, i_csr_fflags_we, i_csr_fflags,
      output o_req0_ready, o_req1_ready, o_issue_valid, o_issue_src, o_issue_rm, o_pipe_en,
      output o_resp_valid, o_resp_src, o_resp_tag, o_resp_illegal, o_resp_fflags, o_frm, o_fflags
   );
endinterface

// File: rtl/fma_issue_ctrl.sv
// fma_issue_ctrl: round-robin issue, rm resolution, in-flight tracking and fflags for the FMA pipeline
// Ports:
//   i_clk : clock
//   i_rst : synchronous active-high reset
//   bus   : fma_issue_ctrl_if.slave carrying requests, issue, pipe flags, response and CSR signals
module fma_issue_ctrl #(
   parameter int PARM_RM      = 3,
   parameter int PARM_LATENCY = 3,
   parameter int PARM_TAG     = 4
) (
   input logic              i_clk,
   input logic              i_rst,
   fma_issue_ctrl_if.slave  bus
);
   localparam int LST = PARM_LATENCY - 1;
   logic                    r_last;
   logic [PARM_LATENCY-1:0] r_v, r_src, r_ill;
   logic [PARM_TAG-1:0]     r_tag [PARM_LATENCY];
   logic [2:0]              r_frm;
   logic [4:0]              r_fflags;
   logic                    w_en, w_g0, w_g1, w_issue, w_hs, w_ill, w_nv, w_of, w_nx, w_uf;
   logic [PARM_RM-1:0]      w_rm_in, w_rm_res;
   logic [PARM_TAG-1:0]     w_tag_in;
   logic [4:0]              w_flags;
   // The whole pipeline freezes only while a response is held back by the consumer.
   assign w_en  = ~(r_v[LST] & ~bus.i_resp_ready);
   // r_last=1 means requester 0 wins the next tie.
   assign w_g0  = w_en & bus.i_req0_valid & (~bus.i_req1_valid | r_last);
   assign w_g1  = w_en & bus.i_req1_valid & (~bus.i_req0_valid | ~r_last);
   assign w_issue  = w_g0 | w_g1;
   assign w_rm_in  = w_g1 ? bus.i_req1_rm : bus.i_req0_rm;
   assign w_tag_in = w_g1 ? bus.i_req1_tag : bus.i_req0_tag;
   // Dynamic rm uses the frm value before any same-cycle CSR write.
   assign w_rm_res = (&w_rm_in) ? PARM_RM'(r_frm) : w_rm_in;
   assign w_ill    = w_rm_res inside {PARM_RM'(5), PARM_RM'(6), PARM_RM'(7)};
   assign w_hs     = r_v[LST] & bus.i_resp_ready;
   assign w_nv  = bus.i_pipe_invalid;
   assign w_of  = bus.i_pipe_overflow & ~w_nv & ~bus.i_pipe_inf_in;
   assign w_nx  = (bus.i_pipe_inexact | w_of) & ~w_nv;
   assign w_uf  = bus.i_pipe_underflow & w_nx & ~w_nv;
   assign w_flags = r_ill[LST] ? 5'b0 : {w_nv, 1'b0, w_of, w_uf, w_nx};
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_last   <= 1'b1;
         r_v      <= '0;
         r_frm    <= 3'b0;
         r_fflags <= 5'b0;
      end else begin
         if (w_issue) r_last <= w_g1;
         if (bus.i_csr_frm_we) r_frm <= bus.i_csr_frm;
         r_fflags <= (bus.i_csr_fflags_we ? bus.i_csr_fflags : r_fflags) | (w_hs ? w_flags : 5'b0);
         if (w_en) begin
            r_v[0]   <= w_issue;
            r_src[0] <= w_g1;
            r_ill[0] <= w_ill;
            r_tag[0] <= w_tag_in;
            for (int i = 1; i < PARM_LATENCY; i++) begin
               r_v[i]   <= r_v[i-1];
               r_src[i] <= r_src[i-1];
               r_ill[i] <= r_ill[i-1];
               r_tag[i] <= r_tag[i-1];
            end
         end
      end
   end
   assign bus.o_req0_ready   = w_g0;
   assign bus.o_req1_ready   = w_g1;
   assign bus.o_issue_valid  = w_issue;
   assign bus.o_issue_src    = w_g1;
   assign bus.o_issue_rm     = w_ill ? '0 : w_rm_res;
   assign bus.o_pipe_en      = w_en;
   assign bus.o_resp_valid   = r_v[LST];
   assign bus.o_resp_src     = r_src[LST];
   assign bus.o_resp_tag     = r_tag[LST];
   assign bus.o_resp_illegal = r_ill[LST];
   assign bus.o_resp_fflags  = w_flags;
   assign bus.o_frm          = r_frm;
   assign bus.o_fflags       = r_fflags;
endmodule

// File: tb/tb_fma_issue_ctrl.sv
// tb_fma_issue_ctrl: directed self-checking bench for fma_issue_ctrl
module tb_fma_issue_ctrl;
   logic clk, rst;
   int   checks, errors;
   fma_issue_ctrl_if #(.PARM_RM(3), .PARM_TAG(4)) bus ();
   fma_issue_ctrl #(.PARM_RM(3), .PARM_LATENCY(3), .PARM_TAG(4)) dut (.i_clk(clk), .i_rst(rst), .bus(bus.slave));
   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end
   task automatic step;
      @(posedge clk);
      @(negedge clk);
   endtask
   task automatic test_reset;
      rst = 1;
      step;
      #1;
      checks++; if (bus.o_resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid: got %b exp 0", bus.o_resp_valid); end
      checks++; if (bus.o_issue_valid !== 1'b0) begin errors++; $display("FAIL reset_issue_valid: got %b exp 0", bus.o_issue_valid); end
      checks++; if (bus.o_frm !== 3'b000) begin errors++; $display("FAIL reset_frm: got %b exp 000", bus.o_frm); end
      checks++; if (bus.o_fflags !== 5'b00000) begin errors++; $display("FAIL reset_fflags: got %b exp 00000", bus.o_fflags); end
      checks++; if (bus.o_pipe_en !== 1'b1) begin errors++; $display("FAIL reset_pipe_en: got %b exp 1", bus.o_pipe_en); end
      rst = 0;
      step;
   endtask
   task automatic test_single;
      bus.i_req0_valid = 1; bus.i_req0_rm = 3'b000; bus.i_req0_tag = 4'd5; bus.i_resp_ready = 1;
      #1;
      checks++; if (bus.o_req0_ready !== 1'b1) begin errors++; $display("FAIL single_ready0: got %b exp 1", bus.o_req0_ready); end
      checks++; if (bus.o_req1_ready !== 1'b0) begin errors++; $display("FAIL single_ready1: got %b exp 0", bus.o_req1_ready); end
      checks++; if (bus.o_issue_valid !== 1'b1 || bus.o_issue_src !== 1'b0) begin errors++; $display("FAIL single_issue: got v=%b src=%b exp v=1 src=0", bus.o_issue_valid, bus.o_issue_src); end
      step;
      bus.i_req0_valid = 0;
      for (int k = 1; k <= 2; k++) begin
         #1;
         checks++; if (bus.o_resp_valid !== 1'b0) begin errors++; $display("FAIL single_early_resp c%0d: got %b exp 0", k, bus.o_resp_valid); end
         step;
      end
      #1;
      checks++; if (bus.o_resp_valid !== 1'b1) begin errors++; $display("FAIL single_resp_valid: got %b exp 1", bus.o_resp_valid); end
      checks++; if (bus.o_resp_tag !== 4'd5 || bus.o_resp_src !== 1'b0) begin errors++; $display("FAIL single_resp_fields: got tag=%0d src=%b exp tag=5 src=0", bus.o_resp_tag, bus.o_resp_src); end
      checks++; if (bus.o_resp_fflags !== 5'b00000) begin errors++; $display("FAIL single_resp_fflags: got %b exp 00000", bus.o_resp_fflags); end
      step;
      #1;
      checks++; if (bus.o_fflags !== 5'b00000) begin errors++; $display("FAIL single_fflags: got %b exp 00000", bus.o_fflags); end
      checks++; if (bus.o_resp_valid !== 1'b0) begin errors++; $display("FAIL single_resp_dup: got %b exp 0", bus.o_resp_valid); end
   endtask
   task automatic test_round_robin;
      rst = 1;
      step;
      rst = 0;
      bus.i_req0_tag = 4'hA; bus.i_req1_tag = 4'hB; bus.i_req0_rm = 3'b000; bus.i_req1_rm = 3'b001;
      for (int c = 0; c < 7; c++) begin
         bus.i_req0_valid = (c < 4); bus.i_req1_valid = (c < 4);
         #1;
         if (c < 4) begin
            checks++; if (bus.o_req0_ready !== ((c % 2) == 0) || bus.o_req1_ready !== ((c % 2) == 1)) begin errors++; $display("FAIL rr_grant c%0d: got r0=%b r1=%b exp src %0d", c, bus.o_req0_ready, bus.o_req1_ready, c % 2); end
         end
         checks++; if (bus.o_resp_valid !== (c >= 3)) begin errors++; $display("FAIL rr_resp_valid c%0d: got %b exp %b", c, bus.o_resp_valid, c >= 3); end
         if (c >= 3) begin
            checks++; if (bus.o_resp_src !== (((c - 3) % 2) == 1) || bus.o_resp_tag !== ((((c - 3) % 2) == 1) ? 4'hB : 4'hA)) begin errors++; $display("FAIL rr_resp_order c%0d: got src=%b tag=%h", c, bus.o_resp_src, bus.o_resp_tag); end
         end
         step;
      end
      #1;
      checks++; if (bus.o_resp_valid !== 1'b0) begin errors++; $display("FAIL rr_resp_extra: got %b exp 0", bus.o_resp_valid); end
   endtask
   task automatic test_stall;
      bus.i_resp_ready = 1;
      bus.i_req0_valid = 1; bus.i_req0_tag = 4'd7; bus.i_req0_rm = 3'b000;
      step;
      bus.i_req0_valid = 0; bus.i_req1_valid = 1; bus.i_req1_tag = 4'd8; bus.i_req1_rm = 3'b000;
      step;
      bus.i_req1_valid = 0;
      #1;
      checks++; if (bus.o_resp_valid !== 1'b0) begin errors++; $display("FAIL stall_early: got %b exp 0", bus.o_resp_valid); end
      step;
      bus.i_resp_ready = 0; bus.i_req0_valid = 1; bus.i_req0_tag = 4'd9;
      #1;
      checks++; if (bus.o_pipe_en !== 1'b0) begin errors++; $display("FAIL stall_pipe_en: got %b exp 0", bus.o_pipe_en); end
      checks++; if (bus.o_req0_ready !== 1'b0 || bus.o_req1_ready !== 1'b0 || bus.o_issue_valid !== 1'b0) begin errors++; $display("FAIL stall_readies: got r0=%b r1=%b iv=%b exp 0", bus.o_req0_ready, bus.o_req1_ready, bus.o_issue_valid); end
      checks++; if (bus.o_resp_valid !== 1'b1 || bus.o_resp_tag !== 4'd7) begin errors++; $display("FAIL stall_resp_c3: got v=%b tag=%0d exp v=1 tag=7", bus.o_resp_valid, bus.o_resp_tag); end
      step;
      #1;
      checks++; if (bus.o_resp_valid !== 1'b1 || bus.o_resp_tag !== 4'd7 || bus.o_pipe_en !== 1'b0) begin errors++; $display("FAIL stall_hold: got v=%b tag=%0d en=%b exp v=1 tag=7 en=0", bus.o_resp_valid, bus.o_resp_tag, bus.o_pipe_en); end
      step;
      bus.i_resp_ready = 1;
      #1;
      checks++; if (bus.o_pipe_en !== 1'b1 || bus.o_resp_tag !== 4'd7 || bus.o_req0_ready !== 1'b1) begin errors++; $display("FAIL stall_release: got en=%b tag=%0d r0=%b exp en=1 tag=7 r0=1", bus.o_pipe_en, bus.o_resp_tag, bus.o_req0_ready); end
      step;
      bus.i_req0_valid = 0;
      #1;
      checks++; if (bus.o_resp_valid !== 1'b1 || bus.o_resp_tag !== 4'd8 || bus.o_resp_src !== 1'b1) begin errors++; $display("FAIL stall_second: got v=%b tag=%0d src=%b exp v=1 tag=8 src=1", bus.o_resp_valid, bus.o_resp_tag, bus.o_resp_src); end
      step;
      #1;
      checks++; if (bus.o_resp_valid !== 1'b0) begin errors++; $display("FAIL stall_gap: got %b exp 0", bus.o_resp_valid); end
      step;
      #1;
      checks++; if (bus.o_resp_valid !== 1'b1 || bus.o_resp_tag !== 4'd9 || bus.o_resp_src !== 1'b0) begin errors++; $display("FAIL stall_third: got v=%b tag=%0d src=%b exp v=1 tag=9 src=0", bus.o_resp_valid, bus.o_resp_tag, bus.o_resp_src); end
      step;
      #1;
      checks++; if (bus.o_resp_valid !== 1'b0) begin errors++; $display("FAIL stall_dup: got %b exp 0", bus.o_resp_valid); end
   endtask
   task automatic test_rm;
      bus.i_resp_ready = 1;
      bus.i_csr_frm_we = 1; bus.i_csr_frm = 3'b010;
      bus.i_req0_valid = 1; bus.i_req0_rm = 3'b111; bus.i_req0_tag = 4'd1;
      #1;
      checks++; if (bus.o_issue_rm !== 3'b000) begin errors++; $display("FAIL rm_old_frm: got %b exp 000", bus.o_issue_rm); end
      step;
      bus.i_csr_frm_we = 0; bus.i_req0_tag = 4'd2;
      #1;
      checks++; if (bus.o_frm !== 3'b010) begin errors++; $display("FAIL rm_frm_write: got %b exp 010", bus.o_frm); end
      checks++; if (bus.o_issue_rm !== 3'b010) begin errors++; $display("FAIL rm_dyn_010: got %b exp 010", bus.o_issue_rm); end
      step;
      bus.i_req0_valid = 0; bus.i_csr_frm_we = 1; bus.i_csr_frm = 3'b101;
      step;
      bus.i_csr_frm_we = 0; bus.i_req0_valid = 1; bus.i_req0_tag = 4'd3;
      #1;
      checks++; if (bus.o_issue_rm !== 3'b000 || bus.o_issue_valid !== 1'b1) begin errors++; $display("FAIL rm_illegal_issue: got rm=%b v=%b exp rm=000 v=1", bus.o_issue_rm, bus.o_issue_valid); end
      checks++; if (bus.o_resp_tag !== 4'd1 || bus.o_resp_illegal !== 1'b0) begin errors++; $display("FAIL rm_resp1: got tag=%0d ill=%b exp tag=1 ill=0", bus.o_resp_tag, bus.o_resp_illegal); end
      step;
      bus.i_req0_valid = 0;
      #1;
      checks++; if (bus.o_resp_tag !== 4'd2 || bus.o_resp_illegal !== 1'b0) begin errors++; $display("FAIL rm_resp2: got tag=%0d ill=%b exp tag=2 ill=0", bus.o_resp_tag, bus.o_resp_illegal); end
      step;
      step;
      bus.i_pipe_invalid = 1; bus.i_pipe_overflow = 1; bus.i_pipe_inexact = 1;
      #1;
      checks++; if (bus.o_resp_valid !== 1'b1 || bus.o_resp_tag !== 4'd3 || bus.o_resp_illegal !== 1'b1) begin errors++; $display("FAIL rm_resp3: got v=%b tag=%0d ill=%b exp v=1 tag=3 ill=1", bus.o_resp_valid, bus.o_resp_tag, bus.o_resp_illegal); end
      checks++; if (bus.o_resp_fflags !== 5'b00000) begin errors++; $display("FAIL rm_illegal_flags: got %b exp 00000", bus.o_resp_fflags); end
      step;
      bus.i_pipe_invalid = 0; bus.i_pipe_overflow = 0; bus.i_pipe_inexact = 0;
      bus.i_csr_frm_we = 1; bus.i_csr_frm = 3'b000;
      #1;
      checks++; if (bus.o_fflags !== 5'b00000) begin errors++; $display("FAIL rm_fflags_clean: got %b exp 00000", bus.o_fflags); end
      step;
      bus.i_csr_frm_we = 0;
   endtask
   task automatic test_flags;
      logic [4:0] vin [6];
      logic [4:0] vexp [6];
      vin[0] = 5'b01000; vexp[0] = 5'b00101;
      vin[1] = 5'b00100; vexp[1] = 5'b00000;
      vin[2] = 5'b11000; vexp[2] = 5'b10000;
      vin[3] = 5'b01001; vexp[3] = 5'b00000;
      vin[4] = 5'b00110; vexp[4] = 5'b00011;
      vin[5] = 5'b00010; vexp[5] = 5'b00001;
      bus.i_resp_ready = 1;
      bus.i_req0_valid = 1; bus.i_req0_rm = 3'b000; bus.i_req0_tag = 4'd4;
      step;
      bus.i_req0_valid = 0;
      step;
      step;
      bus.i_resp_ready = 0;
      for (int k = 0; k < 6; k++) begin
         {bus.i_pipe_invalid, bus.i_pipe_overflow, bus.i_pipe_underflow, bus.i_pipe_inexact, bus.i_pipe_inf_in} = vin[k];
         #1;
         checks++; if (bus.o_resp_valid !== 1'b1 || bus.o_resp_fflags !== vexp[k]) begin errors++; $display("FAIL flags_vec%0d: got v=%b flags=%b exp v=1 flags=%b", k, bus.o_resp_valid, bus.o_resp_fflags, vexp[k]); end
         step;
      end
      {bus.i_pipe_invalid, bus.i_pipe_overflow, bus.i_pipe_underflow, bus.i_pipe_inexact, bus.i_pipe_inf_in} = 5'b0;
      bus.i_resp_ready = 1;
      #1;
      checks++; if (bus.o_fflags !== 5'b00000) begin errors++; $display("FAIL flags_no_hs_accum: got %b exp 00000", bus.o_fflags); end
      step;
      #1;
      checks++; if (bus.o_resp_valid !== 1'b0) begin errors++; $display("FAIL flags_resp_dup: got %b exp 0", bus.o_resp_valid); end
   endtask
   task automatic test_fflags_csr;
      bus.i_resp_ready = 1;
      bus.i_csr_fflags_we = 1; bus.i_csr_fflags = 5'b10000;
      bus.i_req0_valid = 1; bus.i_req0_rm = 3'b000; bus.i_req0_tag = 4'd6;
      step;
      bus.i_csr_fflags_we = 0; bus.i_req0_valid = 0;
      #1;
      checks++; if (bus.o_fflags !== 5'b10000) begin errors++; $display("FAIL fflags_csr_write: got %b exp 10000", bus.o_fflags); end
      step;
      step;
      bus.i_pipe_inexact = 1; bus.i_csr_fflags_we = 1; bus.i_csr_fflags = 5'b00000;
      #1;
      checks++; if (bus.o_resp_valid !== 1'b1 || bus.o_resp_tag !== 4'd6 || bus.o_resp_fflags !== 5'b00001) begin errors++; $display("FAIL fflags_resp: got v=%b tag=%0d flags=%b exp v=1 tag=6 flags=00001", bus.o_resp_valid, bus.o_resp_tag, bus.o_resp_fflags); end
      step;
      bus.i_pipe_inexact = 0; bus.i_csr_fflags_we = 0;
      #1;
      checks++; if (bus.o_fflags !== 5'b00001) begin errors++; $display("FAIL fflags_merge: got %b exp 00001", bus.o_fflags); end
      bus.i_csr_fflags_we = 1; bus.i_csr_fflags = 5'b00000;
      step;
      bus.i_csr_fflags_we = 0;
   endtask
   task automatic test_reset_inflight;
      bus.i_resp_ready = 1;
      bus.i_req0_valid = 1; bus.i_req0_rm = 3'b000; bus.i_req0_tag = 4'd1;
      step;
      bus.i_req0_valid = 0; bus.i_req1_valid = 1; bus.i_req1_rm = 3'b000; bus.i_req1_tag = 4'd2;
      step;
      bus.i_req1_valid = 0; rst = 1;
      step;
      rst = 0;
      for (int k = 0; k < 5; k++) begin
         #1;
         checks++; if (bus.o_resp_valid !== 1'b0) begin errors++; $display("FAIL rst_inflight c%0d: got %b exp 0", k, bus.o_resp_valid); end
         step;
      end
   endtask
   initial begin
      checks = 0; errors = 0; rst = 1;
      bus.i_req0_valid = 0; bus.i_req0_rm = 0; bus.i_req0_tag = 0;
      bus.i_req1_valid = 0; bus.i_req1_rm = 0; bus.i_req1_tag = 0;
      bus.i_pipe_invalid = 0; bus.i_pipe_overflow = 0; bus.i_pipe_underflow = 0; bus.i_pipe_inexact = 0; bus.i_pipe_inf_in = 0;
      bus.i_resp_ready = 1; bus.i_csr_frm_we = 0; bus.i_csr_frm = 0; bus.i_csr_fflags_we = 0; bus.i_csr_fflags = 0;
      @(negedge clk);
      test_reset;
      test_single;
      test_round_robin;
      test_stall;
      test_rm;
      test_flags;
      test_fflags_csr;
      test_reset_inflight;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
